// File: rtl/alu_op_sequencer.sv
// Single-command sequencer in front of a registered, clock-gated 16-bit ALU.
// Optional statistics counters are built when ALU_SEQ_STAT_EN is defined.
module alu_op_sequencer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_fun,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_fun,
    output logic              alu_en,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              arith_flag,
    input  logic              logic_flag,
    input  logic              cmp_flag,
    input  logic              shift_flag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_class,
    output logic              rsp_err,
`ifdef ALU_SEQ_STAT_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_ops,
    output logic [7:0]        stat_errs,
`endif
    output logic              busy
);

    localparam int unsigned FUN_W  = 4;
    localparam int unsigned CLS_W  = 2;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned FLG_W  = 4;
    localparam int unsigned OPS_W  = 16;
    localparam int unsigned ERRS_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [FUN_W-1:0] FUN_DIV     = 4'd3;
    localparam logic [FUN_W-1:0] FUN_ILLEGAL = 4'd15;

    // Function code to result class; the illegal code reports as arith.
    function automatic logic [CLS_W-1:0] class_of(input logic [FUN_W-1:0] f);
        logic [CLS_W-1:0] c;
        if (f <= 4'd3)       c = 2'd0;
        else if (f <= 4'd9)  c = 2'd1;
        else if (f <= 4'd12) c = 2'd2;
        else if (f <= 4'd14) c = 2'd3;
        else                 c = 2'd0;
        return c;
    endfunction

    logic [1:0]        state, state_d;
    logic [CNT_W-1:0]  lat_cnt, lat_cnt_d;
    logic [DATA_W-1:0] alu_a_d, alu_b_d;
    logic [FUN_W-1:0]  alu_fun_d;
    logic              alu_en_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_d;
    logic [CLS_W-1:0]  rsp_class_d;
    logic              rsp_err_d;
    logic [FLG_W-1:0]  flags;
    logic              reject;

    assign flags     = {shift_flag, cmp_flag, logic_flag, arith_flag};
    assign reject    = (cmd_fun == FUN_ILLEGAL) ||
                       ((cmd_fun == FUN_DIV) && (cmd_b == '0));
    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= '0;
            alu_en    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_class <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            lat_cnt   <= lat_cnt_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_fun   <= alu_fun_d;
            alu_en    <= alu_en_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_class <= rsp_class_d;
            rsp_err   <= rsp_err_d;
        end
    end

    // Next-state and next-output logic; ALU operands only change on accept.
    always_comb begin
        state_d     = state;
        lat_cnt_d   = lat_cnt;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_fun_d   = alu_fun;
        rsp_data_d  = rsp_data;
        rsp_class_d = rsp_class;
        rsp_err_d   = rsp_err;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d   = cmd_a;
                    alu_b_d   = cmd_b;
                    alu_fun_d = cmd_fun;
                    if (reject) begin
                        state_d     = RESP;
                        rsp_data_d  = '0;
                        rsp_class_d = class_of(cmd_fun);
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = EXEC;
                        lat_cnt_d = CNT_W'(ALU_LAT - 1);
                    end
                end
            end
            EXEC: begin
                if (lat_cnt == '0) state_d = CAPT;
                else               lat_cnt_d = lat_cnt - CNT_W'(1);
            end
            CAPT: begin
                rsp_data_d  = alu_out;
                rsp_class_d = class_of(alu_fun);
                rsp_err_d   = (flags != (FLG_W'(1) << class_of(alu_fun)));
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        alu_en_d    = (state_d == EXEC);
        rsp_valid_d = (state_d == RESP);
    end

`ifdef ALU_SEQ_STAT_EN
    logic rsp_fire;
    assign rsp_fire = (state == RESP) && rsp_ready;

    // Saturating handshake counters; clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (stat_clr) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (rsp_fire) begin
            if (stat_ops != '1)             stat_ops  <= stat_ops + OPS_W'(1);
            if (rsp_err && stat_errs != '1) stat_errs <= stat_errs + ERRS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with a gated, pipelined ALU model.
// Define ALU_SEQ_STAT_EN to also exercise the statistics counters (ALU_LAT=3).
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_STAT_EN
    localparam int unsigned LAT = 3;
`else
    localparam int unsigned LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_fun = '0;
    logic [15:0] cmd_a = '0, cmd_b = '0;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic        arith_flag, logic_flag, cmp_flag, shift_flag;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_class;
    logic        rsp_err;
    logic        busy;
    logic        stat_clr = 1'b0;
    logic [15:0] stat_ops;
    logic [7:0]  stat_errs;

    int checks = 0;
    int failures = 0;
    int exp_ops = 0;
    int exp_errs = 0;
    logic [3:0] fault_mask = '0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(16), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fun(cmd_fun),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
        .alu_out(alu_out), .arith_flag(arith_flag), .logic_flag(logic_flag),
        .cmp_flag(cmp_flag), .shift_flag(shift_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_class(rsp_class), .rsp_err(rsp_err),
`ifdef ALU_SEQ_STAT_EN
        .stat_clr(stat_clr), .stat_ops(stat_ops), .stat_errs(stat_errs),
`endif
        .busy(busy)
    );

`ifndef ALU_SEQ_STAT_EN
    assign stat_ops  = '0;
    assign stat_errs = '0;
`endif

    function automatic logic [1:0] ref_class(input logic [3:0] f);
        if (f <= 3)  return 2'd0;
        if (f <= 9)  return 2'd1;
        if (f <= 12) return 2'd2;
        if (f <= 14) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [15:0] ref_alu(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return 16'(a * b);
            4'd3:  return (b == 0) ? 16'h0 : a / b;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return ~(a & b);
            4'd7:  return ~(a | b);
            4'd8:  return a ^ b;
            4'd9:  return ~(a ^ b);
            4'd10: return 16'(a == b);
            4'd11: return 16'(a > b);
            4'd12: return 16'(a < b);
            4'd13: return a >> 1;
            4'd14: return a << 1;
            default: return 16'h0;
        endcase
    endfunction

    // ALU model: LAT-deep pipeline advancing only on enabled edges.
    logic [19:0] pipe [LAT] = '{default: '0};
    always @(posedge clk) begin
        if (alu_en) begin
            pipe[0] <= {(4'(1) << ref_class(alu_fun)) ^ fault_mask, ref_alu(alu_fun, alu_a, alu_b)};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign alu_out = pipe[LAT-1][15:0];
    assign {shift_flag, cmp_flag, logic_flag, arith_flag} = pipe[LAT-1][19:16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_stats();
`ifdef ALU_SEQ_STAT_EN
        check("stat_ops", 32'(stat_ops), 32'(exp_ops));
        check("stat_errs", 32'(stat_errs), 32'(exp_errs));
`endif
    endtask

    // Issue one command, wait for its response, hold it, then accept it.
    task automatic run_cmd(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] fault, input int hold, input bit clr);
        bit          rej;
        logic [15:0] e_data;
        logic        e_err;
        int          t, edges, en;
        rej    = (fun == 15) || (fun == 3 && b == 0);
        e_data = rej ? 16'h0 : ref_alu(fun, a, b);
        e_err  = rej || (fault != 0);
        fault_mask = fault;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        check("cmd_ready_wait", 32'(t < 50), 32'd1);
        cmd_valid = 1'b1; cmd_fun = fun; cmd_a = a; cmd_b = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        edges = 0; en = int'(alu_en);
        while (!rsp_valid && edges < 40) begin
            @(posedge clk); #1; edges++; en += int'(alu_en);
        end
        check("rsp_latency", 32'(edges), rej ? 32'd0 : 32'(LAT + 1));
        check("alu_en_cycles", 32'(en), rej ? 32'd0 : 32'(LAT));
        check("rsp_data", 32'(rsp_data), 32'(e_data));
        check("rsp_class", 32'(rsp_class), 32'(ref_class(fun)));
        check("rsp_err", 32'(rsp_err), 32'(e_err));
        check("busy_resp", 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", 32'(rsp_data), 32'(e_data));
            check("hold_err", 32'(rsp_err), 32'(e_err));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        stat_clr  = clr;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        stat_clr  = 1'b0;
        if (clr) begin
            exp_ops = 0; exp_errs = 0;
        end else begin
            exp_ops++; if (e_err) exp_errs++;
        end
        check("post_hs_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_ready", 32'(cmd_ready), 32'd1);
        check_stats();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_outputs", {alu_a, alu_b}, 32'd0);
        check("rst_ctrl", {25'd0, alu_fun, alu_en, rsp_valid, busy}, 32'd0);
        check("rst_rsp", {13'd0, rsp_data, rsp_class, rsp_err}, 32'd0);
        @(negedge clk); rst = 1'b0;

        run_cmd(4'd0, 16'd1, 16'd1, 4'd0, 0, 1'b0);
        run_cmd(4'd6, 16'd1, 16'd1, 4'd0, 5, 1'b0);
        run_cmd(4'd3, 16'd7, 16'd0, 4'd0, 1, 1'b0);
        run_cmd(4'd15, 16'd5, 16'd9, 4'd0, 0, 1'b0);
        run_cmd(4'd10, 16'd1, 16'd1, 4'b0100, 0, 1'b0);

        // Abort during EXEC.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_fun = 4'd0; cmd_a = 16'h1234; cmd_b = 16'h1111;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("exec_before_rst", 32'(alu_en), 32'd1);
        rst = 1'b1; #1;
        check("abort_ctrl", {25'd0, alu_fun, alu_en, rsp_valid, busy}, 32'd0);
        check("abort_ops", {alu_a, alu_b}, 32'd0);
        check("abort_rsp", {13'd0, rsp_data, rsp_class, rsp_err}, 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        exp_ops = 0; exp_errs = 0;
        check_stats();
        @(negedge clk); rst = 1'b0;
        run_cmd(4'd14, 16'd1, 16'd0, 4'd0, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic [3:0]  f, m;
            logic [15:0] a, b;
            f = 4'($urandom_range(0, 15));
            a = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            m = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            run_cmd(f, a, b, m, $urandom_range(0, 3), 1'b0);
        end

`ifdef ALU_SEQ_STAT_EN
        @(negedge clk); stat_clr = 1'b1;
        @(negedge clk); stat_clr = 1'b0;
        exp_ops = 0; exp_errs = 0;
        check_stats();
        run_cmd(4'd0, 16'd3, 16'd4, 4'd0, 0, 1'b0);
        run_cmd(4'd8, 16'hF0F0, 16'h0FF0, 4'd0, 1, 1'b0);
        run_cmd(4'd13, 16'h0100, 16'd0, 4'd0, 0, 1'b0);
        run_cmd(4'd3, 16'd9, 16'd0, 4'd0, 0, 1'b0);
        check("stat_ops_4", 32'(stat_ops), 32'd4);
        check("stat_errs_1", 32'(stat_errs), 32'd1);
        run_cmd(4'd15, 16'd0, 16'd0, 4'd0, 0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
